led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 171 +++++++++++++++++
 tb/tb_led_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer.
// Advances an LED pattern once per edge of the flash-stage output. Four
// patterns are supported: rotate left, rotate right, ping-pong bounce and
// blink-all. The pattern select is sampled only on step events, so a mode
// change takes effect on the next edge by loading the new pattern's start
// value rather than shifting.
module led_sequencer #(
    parameter int LED_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Flash_In,
    input  logic [1:0]       Mode_In,
    input  logic             Pause_In,
    output logic [LED_W-1:0] LED_Out,
    output logic             Step_Out
);

    typedef enum logic [1:0] {
        S_LEFT  = 2'd0,
        S_RIGHT = 2'd1,
        S_PING  = 2'd2,
        S_BLINK = 2'd3
    } state_t;

    localparam logic [1:0] MODE_LEFT  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [LED_W-1:0] PAT_LSB  = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] PAT_MSB  = {1'b1, {(LED_W-1){1'b0}}};
    localparam logic [LED_W-1:0] PAT_ONES = {LED_W{1'b1}};

    // Direction encoding for the ping-pong pattern.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    logic             flash_q;
    logic             step;
    logic             mode_chg;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             step_q, step_d;

    // Rotate left by one, MSB wraps into bit 0.
    function automatic logic [LED_W-1:0] rot_left(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

    // Rotate right by one, bit 0 wraps into the MSB.
    function automatic logic [LED_W-1:0] rot_right(input logic [LED_W-1:0] v);
        return {v[0], v[LED_W-1:1]};
    endfunction

    // State selected by a given mode code.
    function automatic state_t mode_to_state(input logic [1:0] m);
        state_t s;
        case (m)
            MODE_LEFT:  s = S_LEFT;
            MODE_RIGHT: s = S_RIGHT;
            MODE_PING:  s = S_PING;
            default:    s = S_BLINK;
        endcase
        return s;
    endfunction

    // Start pattern loaded when a pattern is (re)entered.
    function automatic logic [LED_W-1:0] start_pattern(input state_t s);
        logic [LED_W-1:0] p;
        case (s)
            S_LEFT:  p = PAT_LSB;
            S_RIGHT: p = PAT_MSB;
            S_PING:  p = PAT_LSB;
            default: p = PAT_ONES;
        endcase
        return p;
    endfunction

    // Edge detector on the flash level; reloading during reset means the
    // first cycle after reset never sees a spurious edge.
    always_ff @(posedge CLK) begin
        flash_q <= Flash_In;
    end

    // Any flash transition is a step unless paused; paused edges are lost
    // because flash_q keeps tracking regardless of Pause_In.
    assign step     = (Flash_In != flash_q) && !Pause_In;
    assign mode_chg = (Mode_In != mode_q);

    // State register: current pattern and the last sampled mode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_LEFT;
            mode_q  <= MODE_LEFT;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: a mode is only adopted on a step event.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (step) begin
            mode_d = Mode_In;
            if (mode_chg) begin
                state_d = mode_to_state(Mode_In);
            end
        end
    end

    // Output logic: a mode change loads the start pattern with no shift,
    // otherwise the current pattern advances one position.
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (step) begin
            step_d = 1'b1;
            if (mode_chg) begin
                led_d = start_pattern(state_d);
                if (state_d == S_PING) begin
                    dir_d = DIR_UP;
                end
            end else begin
                case (state_q)
                    S_LEFT:  led_d = rot_left(led_q);
                    S_RIGHT: led_d = rot_right(led_q);
                    S_PING: begin
                        // Turn around as soon as an end LED is lit so the
                        // end positions are shown only once per bounce.
                        if (dir_q == DIR_UP) begin
                            led_d = led_q << 1;
                            if (led_d[LED_W-1]) begin
                                dir_d = DIR_DOWN;
                            end
                        end else begin
                            led_d = led_q >> 1;
                            if (led_d[0]) begin
                                dir_d = DIR_UP;
                            end
                        end
                    end
                    default: led_d = ~led_q;
                endcase
            end
        end
    end

    // Output registers: LED pattern, ping-pong direction and step pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q  <= PAT_LSB;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign LED_Out  = led_q;
    assign Step_Out = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: a position/direction model of the patterns is
// compared against the DUT on every falling edge, and directed scenarios
// carry hand-computed literal expectations.
module tb_led_sequencer;

    localparam int W = 4;

    logic         CLK;
    logic         RST;
    logic         Flash_In;
    logic [1:0]   Mode_In;
    logic         Pause_In;
    logic [W-1:0] LED_Out;
    logic         Step_Out;

    int n_checks = 0;
    int n_errors = 0;

    led_sequencer #(.LED_W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Flash_In (Flash_In),
        .Mode_In  (Mode_In),
        .Pause_In (Pause_In),
        .LED_Out  (LED_Out),
        .Step_Out (Step_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: pattern as an LED index plus bounce direction / blink phase.
    typedef struct packed {
        logic [1:0] mode;
        int         pos;
        logic       up;
        logic       on;
        logic       flash;
        logic       step;
        logic       valid;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                           input logic fl, input logic [1:0] md,
                                           input logic ps);
        mstate_t n = s;
        n.flash = fl;
        n.step  = 1'b0;
        if (rst) begin
            n.mode  = 2'b00;
            n.pos   = 0;
            n.up    = 1'b1;
            n.on    = 1'b0;
            n.valid = 1'b1;
        end else if (fl != s.flash && !ps) begin
            n.step = 1'b1;
            if (md != s.mode) begin
                n.mode = md;
                case (md)
                    2'd0: n.pos = 0;
                    2'd1: n.pos = W - 1;
                    2'd2: begin n.pos = 0; n.up = 1'b1; end
                    default: n.on = 1'b1;
                endcase
            end else begin
                case (md)
                    2'd0: n.pos = (s.pos + 1) % W;
                    2'd1: n.pos = (s.pos + W - 1) % W;
                    2'd2: begin
                        if (s.up) begin
                            n.pos = s.pos + 1;
                            if (n.pos == W - 1) n.up = 1'b0;
                        end else begin
                            n.pos = s.pos - 1;
                            if (n.pos == 0) n.up = 1'b1;
                        end
                    end
                    default: n.on = !s.on;
                endcase
            end
        end
        return n;
    endfunction

    function automatic logic [W-1:0] model_led(input mstate_t s);
        logic [W-1:0] v = '0;
        if (s.mode == 2'b11) v = s.on ? {W{1'b1}} : '0;
        else v[s.pos] = 1'b1;
        return v;
    endfunction

    always @(posedge CLK) begin
        m <= model_next(m, RST, Flash_In, Mode_In, Pause_In);
    end

    // Continuous comparison against the model once it has seen a reset.
    always @(negedge CLK) begin
        if (m.valid) begin
            n_checks = n_checks + 1;
            if (LED_Out !== model_led(m)) begin
                n_errors = n_errors + 1;
                $display("FAIL model_led t=%0t got=%b exp=%b", $time, LED_Out, model_led(m));
            end
            n_checks = n_checks + 1;
            if (Step_Out !== m.step) begin
                n_errors = n_errors + 1;
                $display("FAIL model_step t=%0t got=%b exp=%b", $time, Step_Out, m.step);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_lit(input string name, input logic [W-1:0] led_exp,
                             input logic step_exp);
        n_checks = n_checks + 1;
        if (LED_Out !== led_exp || Step_Out !== step_exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got led=%b step=%b exp led=%b step=%b",
                     name, LED_Out, Step_Out, led_exp, step_exp);
        end
    endtask

    // Toggle the flash level and advance to the cycle showing the result.
    task automatic flash_edge();
        Flash_In = ~Flash_In;
        tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0] mode;
        logic       pause;
        logic       toggle;
    } vec_t;

    vec_t vecs [0:17] = '{
        '{2'd1, 1'b0, 1'b1}, '{2'd1, 1'b0, 1'b1}, '{2'd1, 1'b0, 1'b0},
        '{2'd2, 1'b1, 1'b1}, '{2'd2, 1'b0, 1'b1}, '{2'd2, 1'b0, 1'b1},
        '{2'd2, 1'b0, 1'b1}, '{2'd3, 1'b0, 1'b1}, '{2'd3, 1'b0, 1'b0},
        '{2'd3, 1'b0, 1'b1}, '{2'd0, 1'b0, 1'b1}, '{2'd0, 1'b0, 1'b1},
        '{2'd2, 1'b0, 1'b1}, '{2'd2, 1'b0, 1'b1}, '{2'd2, 1'b0, 1'b1},
        '{2'd2, 1'b0, 1'b1}, '{2'd2, 1'b0, 1'b1}, '{2'd1, 1'b0, 1'b1}
    };

    logic [W-1:0] seq27 [0:4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [W-1:0] seq28 [0:7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        RST      = 1'b1;
        Flash_In = 1'b1;
        Mode_In  = 2'b00;
        Pause_In = 1'b0;
        tick();
        tick();
        RST = 1'b0;

        // Reset with Flash_In high, then idle: no step appears.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_lit("reset_idle", 4'b0001, 1'b0);
        end

        // Run-left, five edges of alternating polarity.
        for (int i = 0; i < 5; i++) begin
            flash_edge();
            check_lit("run_left", seq27[i], 1'b1);
        end
        tick();
        check_lit("run_left_hold", 4'b0010, 1'b0);

        // Ping-pong from reset: first edge only loads.
        do_reset();
        Mode_In = 2'b10;
        tick();
        check_lit("ping_reset", 4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            flash_edge();
            check_lit("ping_pong", seq28[i], 1'b1);
        end

        // Mode change on a step loads the start pattern without shifting.
        do_reset();
        Mode_In = 2'b00;
        flash_edge();
        flash_edge();
        check_lit("left_at_0100", 4'b0100, 1'b1);
        Mode_In = 2'b01;
        flash_edge();
        check_lit("switch_right_load", 4'b1000, 1'b1);
        flash_edge();
        check_lit("right_step", 4'b0100, 1'b1);

        // Paused edges are discarded with no catch-up on release.
        Pause_In = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flash_edge();
            check_lit("paused", 4'b0100, 1'b0);
        end
        Pause_In = 1'b0;
        tick();
        check_lit("pause_release", 4'b0100, 1'b0);
        flash_edge();
        check_lit("after_pause", 4'b0010, 1'b1);

        // Blink-all, then a reset coinciding with an edge.
        Mode_In = 2'b11;
        flash_edge();
        check_lit("blink_load", 4'b1111, 1'b1);
        flash_edge();
        check_lit("blink_off", 4'b0000, 1'b1);
        flash_edge();
        check_lit("blink_on", 4'b1111, 1'b1);
        Flash_In = ~Flash_In;
        RST      = 1'b1;
        tick();
        check_lit("reset_mid_blink", 4'b0001, 1'b0);
        RST = 1'b0;
        tick();
        check_lit("post_reset_quiet", 4'b0001, 1'b0);
        tick();
        check_lit("post_reset_quiet2", 4'b0001, 1'b0);

        // Mixed directed vectors checked by the model alone.
        for (int i = 0; i < 18; i++) begin
            Mode_In  = vecs[i].mode;
            Pause_In = vecs[i].pause;
            if (vecs[i].toggle) Flash_In = ~Flash_In;
            tick();
        end
        Pause_In = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
